// File: rtl/fifo_drain_ctrl.sv
// Read-side drain engine for syfifo: pops burst_len words and forwards them on a
// valid/ready stream through a 2-entry skid buffer.
module fifo_drain_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_r_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, issued_q, delivered_q, delivered_nxt;
    logic [1:0]       occ_q;
    logic             inflight_q;
    logic [WIDTH-1:0] buf1_q;
    logic             pop;
    logic [2:0]       room_use;

    // Next state and read strobe; the RUN exit looks one pop ahead so done lands right after the last pop
    always_comb begin
        state_d       = state_q;
        fifo_rd_en    = 1'b0;
        pop           = out_valid && out_ready;
        delivered_nxt = delivered_q + CNT_W'(pop);
        room_use      = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        case (state_q)
            IDLE: begin
                if (start) state_d = (burst_len == '0) ? DONE : RUN;
            end
            RUN: begin
                fifo_rd_en = !fifo_empty && (issued_q < len_q) && (room_use < 3'd2);
                if (delivered_nxt == len_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
        end
    end

    // Burst bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (state_q == IDLE && start) begin
                len_q       <= burst_len;
                issued_q    <= '0;
                delivered_q <= '0;
            end else begin
                if (fifo_rd_en) issued_q <= issued_q + CNT_W'(1);
                if (pop)        delivered_q <= delivered_nxt;
            end
        end
    end

    // Skid buffer: out_data is the head entry, buf1_q the second
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            buf1_q    <= '0;
        end else begin
            case ({inflight_q, pop})
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        out_data <= buf1_q;
                        buf1_q   <= fifo_r_data;
                    end else begin
                        out_data <= fifo_r_data;
                    end
                end
                2'b10: begin
                    if (occ_q == 2'd0) out_data <= fifo_r_data;
                    else               buf1_q   <= fifo_r_data;
                    occ_q     <= occ_q + 2'd1;
                    out_valid <= 1'b1;
                end
                2'b01: begin
                    out_data  <= buf1_q;
                    occ_q     <= occ_q - 2'd1;
                    out_valid <= (occ_q == 2'd2);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural syfifo source and a
// scoreboard monitor on the output stream.
module tb_fifo_drain_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] burst_len = '0;
    logic             busy, done;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_r_data = '0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b1;

    fifo_drain_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_r_data(fifo_r_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural syfifo: registered read data, flags updated on the clock
    logic [WIDTH-1:0] fq[$];
    logic             wr_req = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    int               fifo_cnt = 0;
    int               rd_count = 0;
    logic             rd_err = 1'b0;

    assign fifo_empty = (fifo_cnt == 0);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() == 0) rd_err <= 1'b1;
            else begin
                fifo_r_data <= fq.pop_front();
                rd_count++;
            end
        end
        if (wr_req) fq.push_back(wr_data);
        fifo_cnt <= fq.size();
    end

    // Scoreboard monitor: compares every pop and enforces hold under stall
    logic [WIDTH-1:0] exp_q[$];
    logic             hold_pending = 1'b0;
    logic [WIDTH-1:0] hold_data = '0;
    int               done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("pop_without_expected_word", 32'(exp_q.size()), 32'd1);
                else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [WIDTH-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_req  = 1'b1;
            wr_data = base + WIDTH'(i);
            tick();
        end
        wr_req = 1'b0;
    endtask

    task automatic expect_words(input logic [WIDTH-1:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + WIDTH'(i));
    endtask

    task automatic start_burst(input int len);
        start     = 1'b1;
        burst_len = CNT_W'(len);
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin seen = 1'b1; break; end
            tick();
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        tick();
    endtask

    logic [15:0] rd_mask, vld_mask, done_mask, busy_mask;
    int rd0, dn0;

    initial begin
        tick(); tick();
        check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // Basic burst with cycle-exact timing
        preload(8'h11, 1); preload(8'h22, 1); preload(8'h33, 1); preload(8'h44, 1);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        rd_mask = '0; vld_mask = '0; done_mask = '0; busy_mask = '0;
        start_burst(4);
        for (int c = 1; c <= 8; c++) begin
            rd_mask[c] = fifo_rd_en; vld_mask[c] = out_valid;
            done_mask[c] = done; busy_mask[c] = busy;
            tick();
        end
        check("basic_rd_en_cycles", 32'(rd_mask), 32'h001E);
        check("basic_valid_cycles", 32'(vld_mask), 32'h0078);
        check("basic_done_cycles", 32'(done_mask), 32'h0080);
        check("basic_busy_cycles", 32'(busy_mask), 32'h00FE);
        check("basic_fifo_left", 32'(fifo_cnt), 32'd0);

        // Zero length
        rd_mask = '0; vld_mask = '0; done_mask = '0; busy_mask = '0;
        start_burst(0);
        for (int c = 1; c <= 4; c++) begin
            rd_mask[c] = fifo_rd_en; vld_mask[c] = out_valid;
            done_mask[c] = done; busy_mask[c] = busy;
            tick();
        end
        check("zero_rd_en", 32'(rd_mask), 32'h0000);
        check("zero_valid", 32'(vld_mask), 32'h0000);
        check("zero_done", 32'(done_mask), 32'h0002);
        check("zero_busy", 32'(busy_mask), 32'h0002);

        // Backpressure: consumer stalled, only two reads may go out
        preload(8'hA0, 6);
        expect_words(8'hA0, 6);
        out_ready = 1'b0;
        rd0 = rd_count; dn0 = done_cnt;
        start_burst(6);
        for (int c = 1; c <= 10; c++) tick();
        check("stall_reads", 32'(rd_count - rd0), 32'd2);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_head", 32'(out_data), 32'hA0);
        out_ready = 1'b1;
        wait_done("stall");
        tick();
        check("stall_done_once", 32'(done_cnt - dn0), 32'd1);
        check("stall_reads_total", 32'(rd_count - rd0), 32'd6);

        // Starved FIFO: one word arrives every 5 cycles
        expect_words(8'hC0, 3);
        dn0 = done_cnt;
        start_burst(3);
        for (int i = 0; i < 3; i++) begin
            repeat (4) tick();
            preload(8'hC0 + WIDTH'(i), 1);
        end
        wait_done("starve");
        check("starve_done_once", 32'(done_cnt - dn0), 32'd1);
        check("starve_words_left", 32'(exp_q.size()), 32'd0);

        // Over-full source: never read past the burst length
        preload(8'h30, 16);
        expect_words(8'h30, 5);
        rd0 = rd_count;
        start_burst(5);
        wait_done("over1");
        check("over_reads", 32'(rd_count - rd0), 32'd5);
        check("over_fifo_left", 32'(fifo_cnt), 32'd11);
        expect_words(8'h35, 11);
        rd0 = rd_count;
        start_burst(11);
        wait_done("over2");
        check("over2_reads", 32'(rd_count - rd0), 32'd11);
        check("over2_fifo_left", 32'(fifo_cnt), 32'd0);

        // Start while busy is ignored
        preload(8'h50, 8);
        expect_words(8'h50, 4);
        rd0 = rd_count; dn0 = done_cnt;
        start_burst(4);
        tick();
        start_burst(7);
        wait_done("busy_start");
        tick();
        check("busy_start_reads", 32'(rd_count - rd0), 32'd4);
        check("busy_start_done_once", 32'(done_cnt - dn0), 32'd1);
        check("busy_start_fifo_left", 32'(fifo_cnt), 32'd4);
        expect_words(8'h54, 4);
        start_burst(4);
        wait_done("busy_drain");

        // Reset mid-burst, then a fresh burst on the remaining words
        preload(8'h60, 8);
        expect_words(8'h60, 8);
        start_burst(8);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        exp_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_fifo_left", 32'(fifo_cnt), 32'd5);
        expect_words(8'h63, 5);
        start_burst(5);
        wait_done("after_rst");
        check("after_rst_fifo_left", 32'(fifo_cnt), 32'd0);

        tick(); tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("rd_err_never", 32'(rd_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
